gf_poly_area: RTL and testbench
===============================

// Module: gf_poly_area
// PURPOSE
//  Parametrised polygon-area engine for the GF geometry family.
//  - Takes a burst of NPTS vertices, in boundary order and either orientation.
//  - Computes the enclosed area with the shoelace formula.
//  - Re-emits the vertices in counter-clockwise (CCW) order, starting from a canonical anchor vertex.
//  - Generalises coordinate width and vertex count; adds orientation detection and reordering.
// PARAMETERS
//  COORD_W  10           unsigned coordinate width of in_x/in_y/out_x/out_y
//  NPTS     4            vertices per polygon; legal range 3..64
//  AREA_W   2*COORD_W+5  out_area width; result is zero-extended
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        vertex valid; high for exactly NPTS consecutive cycles
//  in_x       in   COORD_W  vertex x, unsigned
//  in_y       in   COORD_W  vertex y, unsigned (y axis points up)
//  out_valid  out  1        output vertex/area valid
//  out_x      out  COORD_W  reordered vertex x
//  out_y      out  COORD_W  reordered vertex y
//  out_area   out  AREA_W   floor(|S|/2); S = sum of x[i]*y[i+1] - x[i+1]*y[i] over i, indices mod NPTS
// BEHAVIOUR
//  - Reset: state IDLE; out_valid, out_x, out_y and out_area all 0; accumulator, count and anchor cleared.
//    Reset asserted mid-operation aborts the polygon immediately; no partial output.
//  - FSM states: IDLE -> LOAD -> CLOSE -> OUT -> IDLE.
//  - IDLE
//    - in_valid=1 stores vertex 0 into buffer[0], sets S=0, anchor=0, goes to LOAD.
//  - LOAD
//    - Each in_valid cycle stores vertex k into buffer[k].
//    - Adds x[k-1]*y[k] - x[k]*y[k-1] to S. S is a signed accumulator of 2*COORD_W+3 bits.
//    - Anchor update: the vertex with minimum y wins; on equal y, minimum x wins.
//      On a full tie, the earliest index is kept.
//    - After vertex NPTS-1 is stored, goes to CLOSE.
//    - in_valid dropping early is a protocol violation. The FSM holds in LOAD (no timeout).
//  - CLOSE (1 cycle)
//    - Adds x[N-1]*y[0] - x[0]*y[N-1] to S.
//    - Latches dir: S>0 -> step +1; S<0 -> step -1; S==0 (degenerate) -> step +1.
//    - Latches area = |S|>>1.
//  - OUT (NPTS cycles)
//    - out_valid=1 for NPTS consecutive cycles.
//    - Cycle j emits buffer[(anchor + dir*j) mod NPTS]. Index wrap-around is exact at both ends.
//    - out_area holds the final area on every valid cycle.
//    - Returns to IDLE after the last vertex.
//  - Latency
//    - Last input sampled at edge t. CLOSE runs in cycle t+1.
//    - First out_valid is seen at edge t+2. The last one is at t+1+NPTS.
//  - Outputs are registered. out_x, out_y and out_area are 0 whenever out_valid=0.
//  - in_valid during CLOSE/OUT is ignored. A new polygon may start on the cycle after the last out_valid.
//  - Area arithmetic
//    - Products are unsigned COORD_W x COORD_W.
//    - Subtraction and accumulation are signed with no overflow, for any NPTS<=64 and full-scale coordinates.
//    - Odd |S| truncates: half units drop.
// TESTING
//  1. NPTS=4: (0,0),(4,0),(4,4),(0,4), CCW
//     -> out (0,0),(4,0),(4,4),(0,4); out_area=16 on all 4 cycles.
//  2. NPTS=4: (4,4),(0,4),(0,0),(4,0)
//     -> anchor (0,0); out (0,0),(4,0),(4,4),(0,4); area=16. Checks wrap-around.
//  3. NPTS=4: (0,0),(0,4),(4,4),(4,0), CW
//     -> reversed output (0,0),(4,0),(4,4),(0,4); area=16.
//  4. NPTS=3: (0,0),(3,0),(0,1) -> area=1 (|S|=3 truncated).
//     Also NPTS=3: (2,5),(2,5),(2,5) -> area=0; three outputs of (2,5).
//  5. NPTS=4, COORD_W=10: (0,0),(1023,0),(1023,1023),(0,1023)
//     -> area=1046529. No overflow.
//  6. Robustness
//     - Assert rst_n low after 2 of 4 vertices: out_valid stays 0 and all outputs read 0.
//     - Then run scenario 1 back-to-back twice: identical outputs both times.
//     - out_valid gap between the two polygons is >=1 cycle.

Source files
------------

// File: rtl/gf_poly_area.sv
// Polygon area engine: buffers NPTS vertices, accumulates the shoelace sum,
// then replays the vertices counter-clockwise from the lowest-leftmost vertex.
module gf_poly_area #(
    parameter int unsigned COORD_W = 10,
    parameter int unsigned NPTS    = 4,
    parameter int unsigned AREA_W  = 2 * COORD_W + 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [COORD_W-1:0]  in_x,
    input  logic [COORD_W-1:0]  in_y,
    output logic                out_valid,
    output logic [COORD_W-1:0]  out_x,
    output logic [COORD_W-1:0]  out_y,
    output logic [AREA_W-1:0]   out_area
);

    localparam int unsigned IDX_W    = $clog2(NPTS);
    localparam int unsigned PROD_W   = 2 * COORD_W;
    localparam int unsigned ACC_MIN  = 2 * COORD_W + 3;
    localparam int unsigned ACC_GROW = 2 * COORD_W + 2 + IDX_W;
    // Wide enough that no partial sum can wrap, even for self-crossing input.
    localparam int unsigned ACC_W    = (ACC_GROW > ACC_MIN) ? ACC_GROW : ACC_MIN;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NPTS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, CLOSE, OUT} state_t;

    state_t                    state;
    logic [IDX_W-1:0]          cnt;
    logic [IDX_W-1:0]          anchor;
    logic [IDX_W-1:0]          idx;
    logic [COORD_W-1:0]        anc_x, anc_y;
    logic [COORD_W-1:0]        prev_x, prev_y;
    logic signed [ACC_W-1:0]   acc;
    logic                      dir_neg;

    logic [COORD_W-1:0]        vbuf_x [NPTS];
    logic [COORD_W-1:0]        vbuf_y [NPTS];

    logic                      wr_c;
    logic [IDX_W-1:0]          wr_idx_c;
    logic [PROD_W-1:0]         pa_c, pb_c, ca_c, cb_c;
    logic signed [ACC_W-1:0]   load_c;
    logic signed [ACC_W-1:0]   close_c;
    logic [ACC_W-1:0]          mag_c;
    logic                      better_c;

    function automatic logic [IDX_W-1:0] step_idx(input logic [IDX_W-1:0] i, input logic neg);
        if (neg)
            return (i == '0) ? LAST : i - 1'b1;
        else
            return (i == LAST) ? '0 : i + 1'b1;
    endfunction

    // Cross-product terms for the incoming edge and the closing edge.
    always_comb begin
        wr_c     = in_valid && (state == IDLE || state == LOAD);
        wr_idx_c = (state == IDLE) ? '0 : cnt;
        pa_c     = PROD_W'(prev_x) * PROD_W'(in_y);
        pb_c     = PROD_W'(in_x) * PROD_W'(prev_y);
        ca_c     = PROD_W'(prev_x) * PROD_W'(vbuf_y[0]);
        cb_c     = PROD_W'(vbuf_x[0]) * PROD_W'(prev_y);
        load_c   = acc + $signed(ACC_W'(pa_c)) - $signed(ACC_W'(pb_c));
        close_c  = acc + $signed(ACC_W'(ca_c)) - $signed(ACC_W'(cb_c));
        mag_c    = close_c[ACC_W-1] ? ACC_W'(-close_c) : ACC_W'(close_c);
        better_c = (in_y < anc_y) || ((in_y == anc_y) && (in_x < anc_x));
    end

    // Vertex storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_c) begin
            vbuf_x[wr_idx_c] <= in_x;
            vbuf_y[wr_idx_c] <= in_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            anchor    <= '0;
            idx       <= '0;
            anc_x     <= '0;
            anc_y     <= '0;
            prev_x    <= '0;
            prev_y    <= '0;
            acc       <= '0;
            dir_neg   <= 1'b0;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_area  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        prev_x <= in_x;
                        prev_y <= in_y;
                        anc_x  <= in_x;
                        anc_y  <= in_y;
                        anchor <= '0;
                        acc    <= '0;
                        cnt    <= IDX_W'(1);
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        prev_x <= in_x;
                        prev_y <= in_y;
                        acc    <= load_c;
                        if (better_c) begin
                            anchor <= cnt;
                            anc_x  <= in_x;
                            anc_y  <= in_y;
                        end
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= CLOSE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                CLOSE: begin
                    // Degenerate (zero) sum keeps the forward direction.
                    dir_neg   <= close_c[ACC_W-1];
                    acc       <= close_c;
                    out_valid <= 1'b1;
                    out_x     <= vbuf_x[anchor];
                    out_y     <= vbuf_y[anchor];
                    out_area  <= AREA_W'(mag_c >> 1);
                    idx       <= step_idx(anchor, close_c[ACC_W-1]);
                    cnt       <= '0;
                    state     <= OUT;
                end
                OUT: begin
                    if (cnt == LAST) begin
                        out_valid <= 1'b0;
                        out_x     <= '0;
                        out_y     <= '0;
                        out_area  <= '0;
                        cnt       <= '0;
                        state     <= IDLE;
                    end else begin
                        out_x <= vbuf_x[idx];
                        out_y <= vbuf_y[idx];
                        idx   <= step_idx(idx, dir_neg);
                        cnt   <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gf_poly_area.sv
// Directed bench for gf_poly_area: a 4-vertex and a 3-vertex instance share
// one stimulus bus; a select flag routes in_valid and picks the observed outputs.
module tb_gf_poly_area;

    localparam int unsigned CW = 10;
    localparam int unsigned AW = 2 * CW + 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [CW-1:0] in_x, in_y;
    logic          use3;

    logic          iv4, iv3;
    logic          ov4, ov3;
    logic [CW-1:0] ox4, oy4, ox3, oy3;
    logic [AW-1:0] oa4, oa3;

    logic          ov;
    logic [CW-1:0] ox, oy;
    logic [AW-1:0] oa;

    int errors = 0;
    int checks = 0;

    int vx[4], vy[4], ex[4], ey[4];

    always #5 clk = ~clk;

    assign iv4 = in_valid & ~use3;
    assign iv3 = in_valid & use3;
    assign ov  = use3 ? ov3 : ov4;
    assign ox  = use3 ? ox3 : ox4;
    assign oy  = use3 ? oy3 : oy4;
    assign oa  = use3 ? oa3 : oa4;

    gf_poly_area #(.COORD_W(CW), .NPTS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_x(in_x), .in_y(in_y),
        .out_valid(ov4), .out_x(ox4), .out_y(oy4), .out_area(oa4)
    );

    gf_poly_area #(.COORD_W(CW), .NPTS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_x(in_x), .in_y(in_y),
        .out_valid(ov3), .out_x(ox3), .out_y(oy3), .out_area(oa3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feed n vertices from vx/vy, then check latency, ordering, area and idle-zero.
    task automatic run_poly(input string tag, input int n, input int area);
        use3 = (n == 3);
        for (int k = 0; k < n; k++) begin
            tick();
            in_valid = 1'b1;
            in_x     = CW'(vx[k]);
            in_y     = CW'(vy[k]);
        end
        tick();
        in_valid = 1'b0;
        in_x     = '0;
        in_y     = '0;
        chk({tag, ".close_valid"}, 32'(ov), 32'd0);
        for (int j = 0; j < n; j++) begin
            tick();
            chk($sformatf("%s.v%0d_valid", tag, j), 32'(ov), 32'd1);
            chk($sformatf("%s.v%0d_x", tag, j), 32'(ox), 32'(ex[j]));
            chk($sformatf("%s.v%0d_y", tag, j), 32'(oy), 32'(ey[j]));
            chk($sformatf("%s.v%0d_area", tag, j), 32'(oa), 32'(area));
        end
        tick();
        chk({tag, ".after_valid"}, 32'(ov), 32'd0);
        chk({tag, ".after_x"}, 32'(ox), 32'd0);
        chk({tag, ".after_area"}, 32'(oa), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_x     = '0;
        in_y     = '0;
        use3     = 1'b0;
        repeat (2) tick();
        chk("reset.valid4", 32'(ov4), 32'd0);
        chk("reset.x4", 32'(ox4), 32'd0);
        chk("reset.area4", 32'(oa4), 32'd0);
        chk("reset.valid3", 32'(ov3), 32'd0);
        rst_n = 1'b1;
        tick();

        // Square, already CCW from (0,0)
        vx = '{0, 4, 4, 0}; vy = '{0, 0, 4, 4};
        ex = '{0, 4, 4, 0}; ey = '{0, 0, 4, 4};
        run_poly("sq_ccw", 4, 16);

        // Same square rotated so the anchor is at index 2
        vx = '{4, 0, 0, 4}; vy = '{4, 4, 0, 0};
        run_poly("sq_rot", 4, 16);

        // Clockwise square: output must run backwards, wrapping below index 0
        vx = '{0, 0, 4, 4}; vy = '{0, 4, 4, 0};
        run_poly("sq_cw", 4, 16);

        // Full-scale square: S = 2*1023*1023
        vx = '{0, 1023, 1023, 0}; vy = '{0, 0, 1023, 1023};
        ex = '{0, 1023, 1023, 0}; ey = '{0, 0, 1023, 1023};
        run_poly("sq_full", 4, 1046529);

        // Triangle with |S|=3 -> area truncates to 1
        vx = '{0, 3, 0, 0}; vy = '{0, 0, 1, 0};
        ex = '{0, 3, 0, 0}; ey = '{0, 0, 1, 0};
        run_poly("tri_odd", 3, 1);

        // Degenerate triangle: all vertices equal
        vx = '{2, 2, 2, 0}; vy = '{5, 5, 5, 0};
        ex = '{2, 2, 2, 0}; ey = '{5, 5, 5, 0};
        run_poly("tri_degen", 3, 0);

        // Reset in the middle of a load: no output may appear
        use3 = 1'b0;
        vx = '{0, 4, 4, 0}; vy = '{0, 0, 4, 4};
        for (int k = 0; k < 2; k++) begin
            tick();
            in_valid = 1'b1;
            in_x     = CW'(vx[k]);
            in_y     = CW'(vy[k]);
        end
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("abort.rst_valid", 32'(ov4), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("abort.idle%0d_valid", c), 32'(ov4), 32'd0);
            chk($sformatf("abort.idle%0d_y", c), 32'(oy4), 32'd0);
        end

        // Scenario one twice in a row after the abort
        ex = '{0, 4, 4, 0}; ey = '{0, 0, 4, 4};
        run_poly("b2b_a", 4, 16);
        run_poly("b2b_b", 4, 16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
